// File: rtl/mem_pkg.sv
// Shared types and constants for the asynchronous SRAM sequencer.
// Holds the FSM state encoding and the idle value of the active-low strobe group.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  typedef struct packed {
    logic ce;
    logic ub;
    logic lb;
    logic oe;
    logic we;
  } strobes_t;

  // All strobes are active-low, so the inactive group is all ones.
  localparam strobes_t STROBES_IDLE = '{ce: 1'b1, ub: 1'b1, lb: 1'b1, oe: 1'b1, we: 1'b1};

  localparam int CNT_W = 4;

  // Address and byte lanes are presented to the memory in SETUP and ACCESS.
  function automatic logic is_bus_phase(input state_t s);
    return (s == ST_SETUP) || (s == ST_ACCESS);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that times the ACCESS phase.
// The zero flag marks the last cycle of the wait window.
module wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             count_down,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (count_down && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_sequencer.sv
// Single-access sequencer for an asynchronous 16-bit SRAM: IDLE/SETUP/ACCESS/RECOVER.
// All memory-facing outputs are registered so reset and state changes never glitch a strobe low.
module mem_sequencer
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        byte_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] A,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_drive,
  input  logic [DATA_W-1:0] Data_in
);

  localparam int LANE_W = DATA_W / 2;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  state_t state_reg;
  state_t state_next;

  logic              lat_we_reg;
  logic              lat_we_next;
  logic [1:0]        lat_be_reg;
  logic [1:0]        lat_be_next;
  logic [ADDR_W-1:0] lat_addr_reg;
  logic [ADDR_W-1:0] lat_addr_next;
  logic [DATA_W-1:0] lat_wdata_reg;
  logic [DATA_W-1:0] lat_wdata_next;

  strobes_t          strobes_reg;
  strobes_t          strobes_next;
  logic              done_reg;
  logic              done_next;
  logic              busy_reg;
  logic              busy_next;
  logic              drive_reg;
  logic              drive_next;
  logic [DATA_W-1:0] rdata_reg;
  logic [DATA_W-1:0] rdata_next;

  logic accept;
  logic cnt_load;
  logic cnt_down;
  logic cnt_zero;
  logic capture;

  assign accept   = (state_reg == ST_IDLE) && req;
  assign cnt_load = (state_reg == ST_SETUP);
  assign cnt_down = (state_reg == ST_ACCESS);

  wait_counter #(
    .CNT_W(CNT_W)
  ) u_wait_counter (
    .clk       (Clk),
    .rst       (Reset),
    .load      (cnt_load),
    .load_value(LOAD_VAL),
    .count_down(cnt_down),
    .zero      (cnt_zero)
  );

  // State and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      lat_we_reg    <= 1'b0;
      lat_be_reg    <= 2'b00;
      lat_addr_reg  <= '0;
      lat_wdata_reg <= '0;
      strobes_reg   <= STROBES_IDLE;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      drive_reg     <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      lat_we_reg    <= lat_we_next;
      lat_be_reg    <= lat_be_next;
      lat_addr_reg  <= lat_addr_next;
      lat_wdata_reg <= lat_wdata_next;
      strobes_reg   <= strobes_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
      drive_reg     <= drive_next;
      rdata_reg     <= rdata_next;
    end
  end

  // Next-state and request latching; req is only looked at in IDLE.
  always_comb begin
    state_next     = state_reg;
    lat_we_next    = lat_we_reg;
    lat_be_next    = lat_be_reg;
    lat_addr_next  = lat_addr_reg;
    lat_wdata_next = lat_wdata_reg;
    case (state_reg)
      ST_IDLE:    if (req) state_next = ST_SETUP;
      ST_SETUP:   state_next = ST_ACCESS;
      ST_ACCESS:  if (cnt_zero) state_next = ST_RECOVER;
      ST_RECOVER: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (accept) begin
      lat_we_next    = we;
      lat_be_next    = byte_en;
      lat_addr_next  = addr;
      lat_wdata_next = wdata;
    end
  end

  // Outputs are decoded from the state being entered, then registered.
  always_comb begin
    logic live;
    logic active;
    live         = (state_next != ST_IDLE);
    active       = |lat_be_next;
    strobes_next = STROBES_IDLE;
    done_next    = (state_next == ST_RECOVER);
    busy_next    = live;
    drive_next   = live && active && lat_we_next;
    if (live && active) begin
      strobes_next.ce = 1'b0;
      if (is_bus_phase(state_next)) begin
        strobes_next.ub = ~lat_be_next[1];
        strobes_next.lb = ~lat_be_next[0];
        strobes_next.oe = lat_we_next;
      end
      if (lat_we_next && (state_next == ST_ACCESS)) begin
        strobes_next.we = 1'b0;
      end
    end
  end

  // Read data is taken on the edge that closes the final ACCESS cycle, lane by lane.
  assign capture = (state_reg == ST_ACCESS) && cnt_zero && !lat_we_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign rdata_next[gi*LANE_W +: LANE_W] = (capture && lat_be_reg[gi])
                                             ? Data_in[gi*LANE_W +: LANE_W]
                                             : rdata_reg[gi*LANE_W +: LANE_W];
    end
  endgenerate

  assign rdata      = rdata_reg;
  assign done       = done_reg;
  assign busy       = busy_reg;
  assign A          = lat_addr_reg;
  assign Data_out   = lat_wdata_reg;
  assign Data_drive = drive_reg;
  assign CE         = strobes_reg.ce;
  assign UB         = strobes_reg.ub;
  assign LB         = strobes_reg.lb;
  assign OE         = strobes_reg.oe;
  assign WE         = strobes_reg.we;

endmodule

// File: tb/tb_mem_sequencer.sv
// Randomized bench for mem_sequencer with a behavioural SRAM and a transaction-level reference.
// Expected strobes and timing come from the cycle offset within each transaction.
module tb_mem_sequencer;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int W      = 2;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              req;
  logic              we;
  logic [1:0]        byte_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] A;
  logic              CE, UB, LB, OE, WE;
  logic [DATA_W-1:0] Data_out;
  logic              Data_drive;
  logic [DATA_W-1:0] Data_in;

  logic [DATA_W-1:0] sram    [256];
  logic [DATA_W-1:0] ref_mem [256];
  logic [DATA_W-1:0] ref_rdata;
  logic              poke_en;
  logic [7:0]        poke_idx;
  logic [DATA_W-1:0] poke_val;
  logic              prev_done;
  int                n_cmp;
  int                n_bad;
  int                n_txn;

  mem_sequencer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .WAIT_CYCLES(W)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .we        (we),
    .byte_en   (byte_en),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .busy      (busy),
    .A         (A),
    .CE        (CE),
    .UB        (UB),
    .LB        (LB),
    .OE        (OE),
    .WE        (WE),
    .Data_out  (Data_out),
    .Data_drive(Data_drive),
    .Data_in   (Data_in)
  );

  always #5 Clk = ~Clk;

  // Asynchronous SRAM model: reads are combinational, writes land on each edge with CE and WE low.
  assign Data_in = sram[A[7:0]];

  always @(posedge Clk) begin
    if (poke_en) begin
      sram[poke_idx] <= poke_val;
    end else if (!CE && !WE) begin
      if (!LB) sram[A[7:0]][7:0]  <= Data_out[7:0];
      if (!UB) sram[A[7:0]][15:8] <= Data_out[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    check("we_oe_overlap", 32'(!WE && !OE), 32'd0);
    check("drive_while_oe", 32'(Data_drive && !OE), 32'd0);
    check("done_width", 32'(prev_done && done), 32'd0);
    prev_done = done;
  end

  // One complete access; entered and left at a negedge with the sequencer idle.
  task automatic do_txn(input logic t_we, input logic [1:0] t_be, input logic [ADDR_W-1:0] t_addr,
                        input logic [DATA_W-1:0] t_wdata, input bit noisy, input bit hold_req);
    logic [7:0]        idx;
    logic [DATA_W-1:0] old_rd;
    logic [DATA_W-1:0] new_rd;
    logic [31:0]       rnd;
    bit                act, in_bus, in_access;
    idx    = t_addr[7:0];
    act    = |t_be;
    old_rd = ref_rdata;
    new_rd = ref_rdata;
    if (!t_we) begin
      if (t_be[0]) new_rd[7:0]  = ref_mem[idx][7:0];
      if (t_be[1]) new_rd[15:8] = ref_mem[idx][15:8];
    end
    check("busy_before", 32'(busy), 32'd0);
    req = 1'b1; we = t_we; byte_en = t_be; addr = t_addr; wdata = t_wdata;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge Clk);
      in_bus    = (k <= W + 1);
      in_access = (k >= 2) && (k <= W + 1);
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), 32'(k == W + 2));
      check("CE", 32'(CE), 32'(!act));
      check("UB", 32'(UB), 32'(!(in_bus && t_be[1])));
      check("LB", 32'(LB), 32'(!(in_bus && t_be[0])));
      check("OE", 32'(OE), 32'(!(in_bus && !t_we && act)));
      check("WE", 32'(WE), 32'(!(in_access && t_we && act)));
      check("A", 32'(A), 32'(t_addr));
      check("rdata", 32'(rdata), 32'((k <= W + 1) ? old_rd : new_rd));
      if (act) check("Data_drive", 32'(Data_drive), 32'(t_we));
      if (act && t_we) check("Data_out", 32'(Data_out), 32'(t_wdata));
      rnd = $urandom;
      if (k == W + 2) begin
        req = hold_req;
      end else if (noisy) begin
        req = rnd[0]; we = rnd[1]; byte_en = rnd[3:2]; addr = {rnd[19:4], 4'h5}; wdata = rnd[31:16];
      end else begin
        req = 1'b0;
      end
    end
    @(negedge Clk);
    check("busy_after", 32'(busy), 32'd0);
    check("done_after", 32'(done), 32'd0);
    check("CE_after", 32'(CE), 32'd1);
    check("rdata_after", 32'(rdata), 32'(new_rd));
    ref_rdata = new_rd;
    if (t_we) begin
      if (t_be[0]) ref_mem[idx][7:0]  = t_wdata[7:0];
      if (t_be[1]) ref_mem[idx][15:8] = t_wdata[15:8];
    end
    check("mem_word", 32'(sram[idx]), 32'(ref_mem[idx]));
    n_txn++;
    $display("txn %0d %s be=%b addr=0x%05h wdata=0x%04h rdata=0x%04h noisy=%0d hold=%0d",
             n_txn, t_we ? "WR" : "RD", t_be, t_addr, t_wdata, rdata, noisy, hold_req);
  endtask

  task automatic reset_mid_write(input logic [ADDR_W-1:0] t_addr, input logic [DATA_W-1:0] t_wdata);
    logic [7:0] idx;
    idx = t_addr[7:0];
    req = 1'b1; we = 1'b1; byte_en = 2'b11; addr = t_addr; wdata = t_wdata;
    @(negedge Clk);
    req = 1'b0;
    @(negedge Clk);
    check("rst_pre_WE", 32'(WE), 32'd0);
    Reset = 1'b1;
    #1;
    check("rst_WE", 32'(WE), 32'd1);
    check("rst_CE", 32'(CE), 32'd1);
    check("rst_OE", 32'(OE), 32'd1);
    check("rst_UB_LB", 32'({UB, LB}), 32'd3);
    check("rst_drive", 32'(Data_drive), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_A", 32'(A), 32'd0);
    check("rst_Data_out", 32'(Data_out), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    for (int k = 0; k < W + 2; k++) begin
      @(negedge Clk);
      check("rst_no_done", 32'(done), 32'd0);
    end
    Reset = 1'b0;
    ref_rdata = '0;
    @(negedge Clk);
    check("rst_idle_busy", 32'(busy), 32'd0);
    check("rst_mem_word", 32'(sram[idx]), 32'(ref_mem[idx]));
    n_txn++;
    $display("txn %0d WR aborted by reset addr=0x%05h", n_txn, t_addr);
  endtask

  initial begin
    logic [31:0]       r1, r2, r3;
    logic [DATA_W-1:0] v;
    n_cmp = 0; n_bad = 0; n_txn = 0; prev_done = 1'b0;
    Reset = 1'b1; req = 1'b0; we = 1'b0; byte_en = 2'b00; addr = '0; wdata = '0;
    poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    ref_rdata = '0;
    @(negedge Clk);
    for (int i = 0; i < 256; i++) begin
      r1 = $urandom;
      v  = (i == 16) ? 16'hBEEF : r1[15:0];
      poke_en = 1'b1; poke_idx = 8'(i); poke_val = v;
      ref_mem[i] = v;
      @(negedge Clk);
    end
    poke_en = 1'b0;
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_busy_done", 32'({busy, done}), 32'd0);
    check("reset_strobes", 32'({CE, UB, LB, OE, WE}), 32'h1F);
    check("reset_drive", 32'(Data_drive), 32'd0);
    check("reset_A", 32'(A), 32'd0);
    check("reset_Data_out", 32'(Data_out), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    do_txn(1'b0, 2'b11, 20'h00010, 16'h0000, 1'b0, 1'b0);
    check("read_beef", 32'(rdata), 32'hBEEF);
    do_txn(1'b0, 2'b00, 20'h00020, 16'h0000, 1'b0, 1'b0);
    check("be00_rdata", 32'(rdata), 32'hBEEF);
    do_txn(1'b1, 2'b01, 20'h0FFFF, 16'h1234, 1'b1, 1'b0);
    do_txn(1'b0, 2'b01, 20'h0FFFF, 16'h0000, 1'b0, 1'b0);
    check("readback_low", 32'(rdata[7:0]), 32'h34);
    do_txn(1'b1, 2'b11, 20'h00033, 16'hA55A, 1'b1, 1'b1);
    do_txn(1'b0, 2'b11, 20'h00033, 16'h0000, 1'b0, 1'b0);
    reset_mid_write(20'h00040, 16'h7777);

    for (int t = 0; t < 40; t++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom;
      do_txn(r1[0], r1[2:1], {r2[19:4], r1[6:3]}, r3[15:0], r1[7], (t != 39) && r1[8] && r1[9]);
    end

    req = 1'b0;
    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, meaning memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning memory data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, range 1..15, meaning ACCESS-state length in clocks.
REQ-004 SHALL have port Clk  input  1  the single clock; all state changes on the rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  1  CPU access request, sampled only in IDLE.
REQ-007 SHALL have port we  input  1  1 = write, 0 = read; latched with req.
REQ-008 SHALL have port byte_en  input  2  [1] upper lane, [0] lower lane; latched with req.
REQ-009 SHALL have port addr  input  ADDR_W  access address; latched with req.
REQ-010 SHALL have port wdata  input  DATA_W  write data; latched with req.
REQ-011 SHALL have port rdata  output  DATA_W  read result, held until next read completes.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port A  output  ADDR_W  memory address.
REQ-015 SHALL have ports CE, UB, LB, OE, WE  output  1 each  active-low memory strobes.
REQ-016 SHALL have port Data_out  output  DATA_W  write data to memory.
REQ-017 SHALL have port Data_drive  output  1  high when Data_out is driven onto the shared bus.
REQ-018 SHALL have port Data_in  input  DATA_W  read data from memory.

Function
REQ-019 SHALL implement states IDLE, SETUP, ACCESS, RECOVER.
REQ-020 SHALL transition IDLE->SETUP on req=1 and latch we, byte_en, addr, wdata; req=0 stays in IDLE.
REQ-021 SHALL transition SETUP->ACCESS after exactly one cycle.
REQ-022 SHALL remain in ACCESS exactly WAIT_CYCLES cycles using a down-counter loaded in SETUP, then go to RECOVER.
REQ-023 SHALL transition RECOVER->IDLE after one cycle and assert done during RECOVER only.
REQ-024 SHALL drive A from the latched address and CE=0 in SETUP, ACCESS and RECOVER; CE=1 in IDLE.
REQ-025 SHALL drive UB=~byte_en[1] and LB=~byte_en[0] in SETUP and ACCESS; both 1 otherwise.
REQ-026 Read: SHALL drive OE=0 in SETUP and ACCESS; WE=1 and Data_drive=0 throughout.
REQ-027 Read: SHALL capture Data_in into rdata at the edge ending the last ACCESS cycle; disabled lanes keep their previous rdata byte.
REQ-028 Write: SHALL drive Data_drive=1 with Data_out=latched wdata in SETUP, ACCESS and RECOVER; WE=0 in ACCESS only; OE=1 throughout.
REQ-029 SHALL give done WAIT_CYCLES+2 cycles after the accepting edge.
REQ-030 SHALL ignore req while busy=1; no queueing.
REQ-031 SHALL accept req in the cycle after RECOVER, so back-to-back spacing is WAIT_CYCLES+3 cycles.
REQ-032 With byte_en=00: SHALL complete with normal timing and done, but hold CE, UB, LB, OE and WE high and leave rdata unchanged.
REQ-033 Write: SHALL never assert WE=0 while OE=0.
REQ-034 Data_drive SHALL never be 1 while OE=0.

Reset
REQ-035 Asserting Reset SHALL immediately force state IDLE, counter 0, rdata 0, done 0, busy 0.
REQ-036 Asserting Reset SHALL immediately force CE, UB, LB, OE, WE to 1, Data_drive 0, A 0, Data_out 0.
REQ-037 Reset mid-transaction SHALL abort with no done pulse, and SHALL produce no glitch low on any strobe.

Structure
REQ-038 The state enum and strobe-default constants SHALL reside in shared package mem_pkg.
REQ-039 The wait counter SHALL be a sub-module wait_counter with load, count-down and zero-flag outputs.

Verification
REQ-040 Read: WAIT_CYCLES=2, addr 0x00010, byte_en 11, memory word 0xBEEF -> OE low for 3 cycles, done 4 cycles after accept, rdata=0xBEEF.
REQ-041 Write: addr 0x0FFFF, wdata 0x1234, byte_en 01 -> WE low for exactly 2 cycles, LB=0, UB=1, Data_drive high 4 cycles, readback low byte 0x34.
REQ-042 Write: req pulsed during ACCESS -> ignored, single done pulse; req held high -> next accept on the cycle after RECOVER.
REQ-043 Reset asserted in ACCESS of a write -> same cycle WE=1, CE=1, Data_drive=0, no done, busy=0.
REQ-044 byte_en=00 read after rdata=0xBEEF -> done at normal time, CE stays high, rdata still 0xBEEF.
REQ-045 Assertion monitor over all tests -> WE=0 and OE=0 never simultaneous, done never wider than one cycle.
